// File: rtl/q_agent_core.sv
// Tabular Q-learning sequencer: scans Q(s',.) for max/argmax, applies the one-step update to the
// previous (s,a) pair and issues an epsilon-greedy action driven by a free-running Galois LFSR.
module q_agent_core #(
  parameter int unsigned N_STATES    = 64,
  parameter int unsigned N_ACTIONS   = 4,
  parameter int unsigned Q_W         = 16,
  parameter int unsigned ALPHA_SHIFT = 2,
  parameter int unsigned GAMMA_SHIFT = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int unsigned S_W        = $clog2(N_STATES),
  localparam int unsigned A_W        = $clog2(N_ACTIONS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  new_episode,
  input  logic                  learn_en,
  input  logic [S_W-1:0]        next_state,
  input  logic signed [Q_W-1:0] reward,
  input  logic [7:0]            epsilon,
  output logic                  busy,
  output logic [A_W-1:0]        action,
  output logic                  action_valid,
  output logic [S_W-1:0]        curr_state
);

  localparam int unsigned E_W   = Q_W + 3;
  localparam int unsigned N_ENT = N_STATES * N_ACTIONS;
  localparam logic signed [E_W-1:0] QMax = {4'b0000, {(Q_W-1){1'b1}}};
  localparam logic signed [E_W-1:0] QMin = {4'b1111, {(Q_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StScan, StUpdate, StWrite, StSelect} state_e;

  state_e                         st_q;
  logic [N_ENT-1:0][Q_W-1:0]      q_q;
  logic [S_W-1:0]                 s_q, sn_q;
  logic [A_W-1:0]                 a_q, idx_q, arg_q, action_q;
  logic                           have_prev_q, learn_q, busy_q, valid_q;
  logic signed [Q_W-1:0]          r_q, max_q, qnew_q;
  logic [7:0]                     eps_q;
  logic [15:0]                    lfsr_q, lfsr_d;

  logic [S_W+A_W-1:0]             rd_idx;
  logic signed [Q_W-1:0]          rd_val, qnew_d;
  logic signed [E_W-1:0]          max_e, r_e, old_e, target, delta, sum;
  logic                           explore;
  logic [A_W-1:0]                 sel_act;

  // Single read port: the scan walks row s', the update reads the previous (s,a) entry.
  assign rd_idx = (st_q == StUpdate) ? {s_q, a_q} : {sn_q, idx_q};
  assign rd_val = $signed(q_q[rd_idx]);

  always_comb begin
    max_e  = {{3{max_q[Q_W-1]}}, max_q};
    r_e    = {{3{r_q[Q_W-1]}}, r_q};
    old_e  = {{3{rd_val[Q_W-1]}}, rd_val};
    target = r_e + max_e - (max_e >>> GAMMA_SHIFT);
    delta  = target - old_e;
    sum    = old_e + (delta >>> ALPHA_SHIFT);
    qnew_d = sum[Q_W-1:0];
    if (sum > QMax) begin
      qnew_d = QMax[Q_W-1:0];
    end else if (sum < QMin) begin
      qnew_d = QMin[Q_W-1:0];
    end
  end

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  assign lfsr_d  = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400) : {1'b0, lfsr_q[15:1]};
  assign explore = lfsr_q[7:0] < eps_q;
  assign sel_act = explore ? lfsr_q[8 +: A_W] : arg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= StIdle;
      q_q         <= '0;
      s_q         <= '0;
      sn_q        <= '0;
      a_q         <= '0;
      idx_q       <= '0;
      arg_q       <= '0;
      action_q    <= '0;
      have_prev_q <= 1'b0;
      learn_q     <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      r_q         <= '0;
      max_q       <= '0;
      qnew_q      <= '0;
      eps_q       <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      lfsr_q  <= lfsr_d;
      valid_q <= 1'b0;
      unique case (st_q)
        StIdle: begin
          if (start) begin
            sn_q    <= next_state;
            r_q     <= reward;
            eps_q   <= epsilon;
            learn_q <= learn_en;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            st_q    <= StScan;
            if (new_episode) begin
              have_prev_q <= 1'b0;
            end
          end
        end
        StScan: begin
          // Strict compare keeps the lowest index on ties.
          if ((idx_q == '0) || (rd_val > max_q)) begin
            max_q <= rd_val;
            arg_q <= idx_q;
          end
          idx_q <= idx_q + 1'b1;
          if (idx_q == A_W'(N_ACTIONS - 1)) begin
            st_q <= (have_prev_q && learn_q) ? StUpdate : StSelect;
          end
        end
        StUpdate: begin
          qnew_q <= qnew_d;
          st_q   <= StWrite;
        end
        StWrite: begin
          q_q[{s_q, a_q}] <= qnew_q;
          st_q            <= StSelect;
        end
        StSelect: begin
          action_q    <= sel_act;
          valid_q     <= 1'b1;
          s_q         <= sn_q;
          a_q         <= sel_act;
          have_prev_q <= 1'b1;
          busy_q      <= 1'b0;
          st_q        <= StIdle;
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign busy         = busy_q;
  assign action       = action_q;
  assign action_valid = valid_q;
  assign curr_state   = s_q;

endmodule

// File: tb/tb_q_agent_core.sv
// Directed and randomized bench for q_agent_core, checked against an arithmetic Q-learning model
// and a reference LFSR stream.
module tb_q_agent_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        new_episode = 1'b0;
  logic        learn_en = 1'b0;
  logic [5:0]  next_state = '0;
  logic [15:0] reward = '0;
  logic [7:0]  epsilon = '0;
  logic        busy;
  logic [1:0]  action;
  logic        action_valid;
  logic [5:0]  curr_state;

  q_agent_core dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .new_episode  (new_episode),
    .learn_en     (learn_en),
    .next_state   (next_state),
    .reward       (reward),
    .epsilon      (epsilon),
    .busy         (busy),
    .action       (action),
    .action_valid (action_valid),
    .curr_state   (curr_state)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int qm [256];
  int m_s = 0;
  int m_a = 0;
  bit m_hp = 1'b0;
  int n_explore = 0;

  // Reference random stream: reset to the seed, advance on every clock edge.
  logic [15:0] rl, rl_prev;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rl      <= 16'hACE1;
      rl_prev <= 16'hACE1;
    end else begin
      rl_prev <= rl;
      rl      <= lfsr_next(rl);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [31:0] dut_q(input int i);
    logic [15:0] v;
    v = dut.q_q[i];
    return {{16{v[15]}}, v};
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) qm[i] = 0;
    m_s = 0;
    m_a = 0;
    m_hp = 1'b0;
  endtask

  task automatic check_table(input string tag);
    int diffs;
    diffs = 0;
    for (int i = 0; i < 256; i++) begin
      if (dut_q(i) !== qm[i]) diffs++;
    end
    chk(tag, diffs, 0);
  endtask

  // One agent step; hold>0 keeps start asserted for that many busy cycles (must be ignored).
  task automatic do_step(input bit ne, input bit le, input int sn, input int r, input int eps,
                         input int hold);
    int n, mx, am, lat, act, tgt, qn, pulses;
    bit got, upd, expl;
    @(negedge clk);
    start = 1'b1;
    new_episode = ne;
    learn_en = le;
    next_state = sn[5:0];
    reward = r[15:0];
    epsilon = eps[7:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    new_episode = 1'($urandom);
    learn_en = 1'($urandom);
    reward = 16'($urandom);
    epsilon = 8'($urandom);
    chk("busy_rise", busy, 1);

    if (ne) m_hp = 1'b0;
    upd = m_hp && le;
    mx = qm[sn * 4];
    am = 0;
    for (int i = 1; i < 4; i++) begin
      if (qm[sn * 4 + i] > mx) begin
        mx = qm[sn * 4 + i];
        am = i;
      end
    end
    if (upd) begin
      tgt = r + mx - (mx >>> 3);
      qn = qm[m_s * 4 + m_a] + ((tgt - qm[m_s * 4 + m_a]) >>> 2);
      qm[m_s * 4 + m_a] = sat16(qn);
    end
    lat = upd ? 7 : 5;

    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      start = (n < hold);
      next_state = 6'($urandom);
      @(posedge clk);
      #1;
      n++;
      got = (action_valid === 1'b1);
    end
    start = 1'b0;
    chk("latency", n, lat);
    act = am;
    if (got) begin
      expl = rl_prev[7:0] < eps[7:0];
      if (expl) begin
        act = int'(rl_prev[9:8]);
        n_explore++;
      end
      chk("action", action, act);
      chk("curr_state", curr_state, sn);
      chk("busy_fall", busy, 0);
    end
    if (hold > 0) begin
      pulses = 0;
      repeat (4) begin
        @(posedge clk);
        #1;
        if (action_valid) pulses++;
      end
      chk("extra_pulse", pulses, 0);
    end
    m_s = sn;
    m_a = act;
    m_hp = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", action_valid, 0);
    chk("rst_action", action, 0);
    chk("rst_state", curr_state, 0);
    check_table("rst_table");
    @(negedge clk);
    rst = 1'b0;

    // Directed learning sequence.
    do_step(1'b1, 1'b1, 5, 100, 0, 0);
    check_table("step1_table");
    do_step(1'b0, 1'b1, 6, 100, 0, 0);
    chk("q_5_0", dut_q(5 * 4 + 0), 25);
    do_step(1'b0, 1'b1, 5, 0, 0, 0);
    chk("q_6_0", dut_q(6 * 4 + 0), 5);

    // Start held high while busy must not launch extra steps.
    do_step(1'b0, 1'b1, 20, 50, 0, 3);
    check_table("ctrl_table");

    // Positive then negative saturation on row 10.
    do_step(1'b1, 1'b1, 10, 0, 0, 0);
    for (int i = 0; i < 12; i++) do_step(1'b0, 1'b1, 10, 32767, 0, 0);
    chk("sat_pos", dut_q(10 * 4 + 0), 32767);
    for (int i = 0; i < 60; i++) do_step(1'b0, 1'b1, 10, -32768, 0, 0);
    chk("sat_neg", dut_q(10 * 4 + 0), -32768);
    check_table("sat_table");

    // Pure exploration, no learning: actions follow the LFSR and the table is frozen.
    for (int i = 0; i < 256; i++) do_step(1'b0, 1'b0, int'($urandom_range(63)), 1000, 255, 0);
    check_table("explore_table");

    // Random mixed traffic.
    for (int i = 0; i < 300; i++) begin
      do_step(($urandom_range(15) == 0), 1'($urandom), int'($urandom_range(63)),
              int'($signed(16'($urandom))), int'($urandom_range(255)), 0);
    end
    check_table("random_table");

    // Explore rate at epsilon=64 should be near 25%.
    n_explore = 0;
    for (int i = 0; i < 4096; i++) do_step(1'b0, 1'b0, int'($urandom_range(63)), 0, 64, 0);
    chk("explore_frac", (n_explore >= 901 && n_explore <= 1146), 1);

    // Reset asserted during SCAN aborts the step and clears everything immediately.
    @(negedge clk);
    start = 1'b1;
    new_episode = 1'b0;
    learn_en = 1'b1;
    next_state = 6'd7;
    reward = 16'd300;
    epsilon = 8'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("abort_busy", busy, 0);
    chk("abort_valid", action_valid, 0);
    chk("abort_action", action, 0);
    chk("abort_state", curr_state, 0);
    check_table("abort_table");
    @(negedge clk);
    rst = 1'b0;
    do_step(1'b1, 1'b1, 5, 100, 0, 0);
    do_step(1'b0, 1'b1, 6, 100, 0, 0);
    chk("q_5_0_again", dut_q(5 * 4 + 0), 25);
    check_table("final_table");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
